// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the write-back result mux, MDU, hazard unit and the
// register-file write port. The arbiter uses the slave view.
interface wb_port_arbiter_if;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic [4:0]  hz_rs1;
  logic [4:0]  hz_rs2;
  logic        hz_pend;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport slave (
    input  RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_result, hz_rs1, hz_rs2,
    output mdu_ready, hz_pend, wb_stall, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_result, hz_rs1, hz_rs2,
    input  mdu_ready, hz_pend, wb_stall, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port scheduler: pipeline writes win, MDU results queue for free slots.
// Optional starvation guard (registered wb_stall) built when WB_ARB_STARVE_EN is defined.
module wb_port_arbiter #(
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  wb_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : gBadParam
    $error("wb_port_arbiter: QDEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [QDEPTH-1:0] qLive;
  logic [4:0]        qRd   [QDEPTH];
  logic [31:0]       qData [QDEPTH];
  logic [PW-1:0]     rdPtr, wrPtr;
  logic [CW-1:0]     count;

  logic slotBusy, qEmpty, headLive, popLive, popDead, pop;
  logic mduReady, cutThru, enq, enqLive, pend;

  function automatic logic srcHit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2);
    return (rd == rs1 && rs1 != 5'd0) || (rd == rs2 && rs2 != 5'd0);
  endfunction

  always_comb begin
    slotBusy = bus.RegWriteW && (bus.RdW != 5'd0);
    qEmpty   = (count == '0);
    headLive = !qEmpty && qLive[rdPtr];
    popLive  = !slotBusy && headLive;
    // a killed head leaves without touching the port, even under a busy slot
    popDead  = !qEmpty && !qLive[rdPtr];
    pop      = popLive || popDead;
    mduReady = rst && (count < CW'(QDEPTH));
    cutThru  = !slotBusy && qEmpty && bus.mdu_valid && (bus.mdu_rd != 5'd0);
    enq      = bus.mdu_valid && mduReady && !cutThru && (bus.mdu_rd != 5'd0);
    enqLive  = !(slotBusy && bus.mdu_rd == bus.RdW);
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (slotBusy) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.RdW;
      bus.rf_wdata = bus.ResultW;
    end else if (headLive) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = qRd[rdPtr];
      bus.rf_wdata = qData[rdPtr];
    end else if (cutThru) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.mdu_rd;
      bus.rf_wdata = bus.mdu_result;
    end
    bus.rf_we = bus.rf_we && rst;
  end

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (qLive[i] && srcHit(qRd[i], bus.hz_rs1, bus.hz_rs2)) pend = 1'b1;
    end
    if (enq && enqLive && srcHit(bus.mdu_rd, bus.hz_rs1, bus.hz_rs2)) pend = 1'b1;
    bus.hz_pend = pend && rst;
  end

  assign bus.mdu_ready = mduReady;

  // Free slots keep live=0, so qLive alone marks the occupied, still-valid entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qLive <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (slotBusy && qRd[i] == bus.RdW) qLive[i] <= 1'b0;
      end
      if (popLive) qLive[rdPtr] <= 1'b0;
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (enq) begin
        qLive[wrPtr] <= enqLive;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (enq && !pop)      count <= count + 1'b1;
      else if (!enq && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      qRd[wrPtr]   <= bus.mdu_rd;
      qData[wrPtr] <= bus.mdu_result;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starveCnt;
  logic          wbStallQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveCnt <= '0;
      wbStallQ  <= 1'b0;
    end else begin
      if (pop || qEmpty)
        starveCnt <= '0;
      else if (headLive && starveCnt != SW'(STARVE_LIMIT))
        starveCnt <= starveCnt + 1'b1;
      if (pop)
        wbStallQ <= 1'b0;
      else if (headLive && starveCnt == SW'(STARVE_LIMIT - 1))
        wbStallQ <= 1'b1;
    end
  end

  assign bus.wb_stall = wbStallQ;
`else
  assign bus.wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboarded bench for wb_port_arbiter: expected port writes are queued by the
// stimulus and checked by a monitor; control outputs are checked inline.
module tb_wb_port_arbiter;

`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [36:0] expQ[$];

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.QDEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.RegWriteW  = rw;
    bus.RdW        = rd;
    bus.ResultW    = res;
    bus.mdu_valid  = mv;
    bus.mdu_rd     = mrd;
    bus.mdu_result = mres;
    bus.hz_rs1     = rs1;
    bus.hz_rs2     = rs2;
  endtask

  task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs1, rs2);
  endtask

  task automatic expWr(input logic [4:0] a, input logic [31:0] d);
    expQ.push_back({a, d});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every port write must match the oldest expected write.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (bus.rf_we !== 1'b0) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rf_write_unexpected: got we=%b x%0d=%h, required no write",
                   bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end else begin
          e = expQ.pop_front();
          if ({bus.rf_waddr, bus.rf_wdata} !== e) begin
            errors++;
            $display("FAIL rf_write: got x%0d=%h, required x%0d=%h",
                     bus.rf_waddr, bus.rf_wdata, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    // reset with active-looking inputs
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 32'h77, 5'd5, 5'd5);
    @(negedge clk);
    chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset_mdu_ready", 32'(bus.mdu_ready), 32'd0);
    chk("reset_hz_pend", 32'(bus.hz_pend), 32'd0);
    chk("reset_wb_stall", 32'(bus.wb_stall), 32'd0);
    idle(5'd0, 5'd0);
    #2 rst = 1'b1;
    nxt();

    // cut-through
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 5'd0, 5'd0);
    expWr(5'd7, 32'h1234);
    @(negedge clk);
    chk("cut_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    nxt();
    idle(5'd7, 5'd0);
    @(negedge clk);
    chk("cut_not_queued", 32'(bus.hz_pend), 32'd0);
    nxt();

    // queue fill under busy slots, then drain in order
    drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd8, 32'h800, 5'd9, 5'd0);
    expWr(5'd3, 32'h300);
    nxt();
    drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd9, 32'h900, 5'd9, 5'd0);
    expWr(5'd3, 32'h301);
    @(negedge clk);
    chk("fill_pend_incoming", 32'(bus.hz_pend), 32'd1);
    nxt();
    drive(1'b1, 5'd3, 32'h302, 1'b1, 5'd10, 32'hA00, 5'd9, 5'd0);
    expWr(5'd3, 32'h302);
    @(negedge clk);
    chk("fill_full_ready", 32'(bus.mdu_ready), 32'd0);
    chk("fill_pend_x9", 32'(bus.hz_pend), 32'd1);
    nxt();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA00, 5'd9, 5'd0);
    expWr(5'd8, 32'h800);
    @(negedge clk);
    chk("pop_no_ready_raise", 32'(bus.mdu_ready), 32'd0);
    nxt();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA00, 5'd9, 5'd0);
    expWr(5'd9, 32'h900);
    @(negedge clk);
    chk("ready_after_pop", 32'(bus.mdu_ready), 32'd1);
    nxt();
    idle(5'd9, 5'd0);
    expWr(5'd10, 32'hA00);
    @(negedge clk);
    chk("x9_drained_pend", 32'(bus.hz_pend), 32'd0);
    nxt();

    // kill of a queued entry by a younger pipeline write
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd4, 32'hAA, 5'd4, 5'd0);
    expWr(5'd1, 32'h100);
    @(negedge clk);
    chk("kill_pend_before", 32'(bus.hz_pend), 32'd1);
    nxt();
    drive(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    expWr(5'd4, 32'h4444);
    nxt();
    idle(5'd4, 5'd0);
    @(negedge clk);
    chk("dead_pop_no_write", 32'(bus.rf_we), 32'd0);
    chk("dead_pend", 32'(bus.hz_pend), 32'd0);
    nxt();
    // incoming entry killed in the same cycle
    drive(1'b1, 5'd6, 32'h600, 1'b1, 5'd6, 32'h666, 5'd0, 5'd6);
    expWr(5'd6, 32'h600);
    @(negedge clk);
    chk("kill_incoming_pend", 32'(bus.hz_pend), 32'd0);
    nxt();
    idle(5'd0, 5'd6);
    @(negedge clk);
    chk("kill_incoming_no_write", 32'(bus.rf_we), 32'd0);
    nxt();

    // x0 handling
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD, 5'd0, 5'd0);
    @(negedge clk);
    chk("x0_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    chk("x0_no_write", 32'(bus.rf_we), 32'd0);
    nxt();
    idle(5'd0, 5'd0);
    @(negedge clk);
    chk("x0_discarded", 32'(bus.rf_we), 32'd0);
    nxt();
    drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd12, 32'hC00, 5'd12, 5'd0);
    expWr(5'd2, 32'h200);
    nxt();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    expWr(5'd12, 32'hC00);
    @(negedge clk);
    chk("x0_slot_pend", 32'(bus.hz_pend), 32'd1);
    nxt();
    idle(5'd12, 5'd0);
    @(negedge clk);
    chk("x0_slot_drained", 32'(bus.hz_pend), 32'd0);
    nxt();

    // starvation: one entry held off by continuous pipeline writes
    drive(1'b1, 5'd3, 32'h310, 1'b1, 5'd13, 32'hD00, 5'd13, 5'd0);
    expWr(5'd3, 32'h310);
    nxt();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 5'd3, 32'h310 + 32'(k), 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
      expWr(5'd3, 32'h310 + 32'(k));
      @(negedge clk);
      chk($sformatf("starve_stall_c%0d", k), 32'(bus.wb_stall),
          32'(STARVE_ON && k == 5));
      nxt();
    end
    idle(5'd13, 5'd0);
    expWr(5'd13, 32'hD00);
    @(negedge clk);
    chk("starve_stall_drain", 32'(bus.wb_stall), 32'(STARVE_ON));
    nxt();
    idle(5'd0, 5'd0);
    @(negedge clk);
    chk("starve_stall_fall", 32'(bus.wb_stall), 32'd0);
    nxt();

    // reset mid-drain discards queued results
    drive(1'b1, 5'd3, 32'h320, 1'b1, 5'd14, 32'hE00, 5'd14, 5'd0);
    expWr(5'd3, 32'h320);
    nxt();
    drive(1'b1, 5'd3, 32'h321, 1'b1, 5'd15, 32'hF00, 5'd14, 5'd0);
    expWr(5'd3, 32'h321);
    nxt();
    idle(5'd14, 5'd15);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("midreset_ready", 32'(bus.mdu_ready), 32'd0);
    #2 rst = 1'b1;
    nxt();
    @(negedge clk);
    chk("after_reset_pend", 32'(bus.hz_pend), 32'd0);
    chk("after_reset_ready", 32'(bus.mdu_ready), 32'd1);
    nxt();
    @(negedge clk);
    nxt();

    @(negedge clk);
    chk("pending_writes", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
